// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : shared widths and types for the 8-bit core's return stack
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int AW       = 8;
  localparam int RS_DEPTH = 8;
  localparam int RS_SPW   = $clog2(RS_DEPTH) + 1;
  localparam int RS_IW    = $clog2(RS_DEPTH);

  typedef logic [AW-1:0]     addr_t;
  typedef logic [RS_SPW-1:0] rs_cnt_t;

  typedef enum logic [1:0] {
    RS_IDLE    = 2'd0,
    RS_PUSH    = 2'd1,
    RS_POP     = 2'd2,
    RS_REPLACE = 2'd3
  } rs_op_e;

  function automatic rs_op_e rs_decode(input logic push, input logic pop);
    rs_op_e op;
    case ({push, pop})
      2'b10:   op = RS_PUSH;
      2'b01:   op = RS_POP;
      2'b11:   op = RS_REPLACE;
      default: op = RS_IDLE;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/return_stack_if.sv
// ---------------------------------------------------------------------------
// return_stack_if : control-unit strobes and stack status
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface return_stack_if;
  import cpu_pkg::*;

  logic    push;
  addr_t   push_addr;
  logic    pop;
  logic    clear_err;
  addr_t   top_addr;
  rs_cnt_t count;
  logic    empty;
  logic    full;
  logic    overflow;
  logic    underflow;

  modport master (
    output push, push_addr, pop, clear_err,
    input  top_addr, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, push_addr, pop, clear_err,
    output top_addr, count, empty, full, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/sticky_flag.sv
// ---------------------------------------------------------------------------
// sticky_flag : set/clear flag, set has priority over clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sticky_flag (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic set,
  input  wire logic clr,
  output logic      flag
);

  logic flag_d;
  logic flag_q;

  always_comb begin
    flag_d = set | (flag_q & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

`default_nettype wire

// File: rtl/return_stack.sv
// ---------------------------------------------------------------------------
// return_stack : CALL/RET return-address LIFO with registered top and sticky errors
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module return_stack
  import cpu_pkg::*;
(
  input wire logic      clk,
  input wire logic      rst,
  return_stack_if.slave bus
);

  localparam rs_cnt_t C_CNT_ONE  = RS_SPW'(1);
  localparam rs_cnt_t C_CNT_TWO  = RS_SPW'(2);
  localparam rs_cnt_t C_CNT_FULL = RS_SPW'(RS_DEPTH);

  addr_t   mem_q [RS_DEPTH];
  addr_t   mem_d [RS_DEPTH];
  addr_t   top_d;
  addr_t   top_q;
  rs_cnt_t count_d;
  rs_cnt_t count_q;
  rs_cnt_t cnt_m1;
  rs_cnt_t cnt_m2;
  logic    empty;
  logic    full;
  logic    ovf_set;
  logic    unf_set;
  rs_op_e  op;

  assign empty  = (count_q == '0);
  assign full   = (count_q == C_CNT_FULL);
  assign cnt_m1 = count_q - C_CNT_ONE;
  assign cnt_m2 = count_q - C_CNT_TWO;
  assign op     = rs_decode(bus.push, bus.pop);

  always_comb begin
    mem_d   = mem_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      RS_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          mem_d[count_q[RS_IW-1:0]] = bus.push_addr;
          count_d                   = count_q + C_CNT_ONE;
          top_d                     = bus.push_addr;
        end
      end
      RS_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          count_d = cnt_m1;
          // New top is the entry below the current one; nothing left shows as 0
          top_d   = (count_q >= C_CNT_TWO) ? mem_q[cnt_m2[RS_IW-1:0]] : '0;
        end
      end
      RS_REPLACE: begin
        if (empty) begin
          mem_d[0] = bus.push_addr;
          count_d  = C_CNT_ONE;
          top_d    = bus.push_addr;
          unf_set  = 1'b1;
        end else begin
          mem_d[cnt_m1[RS_IW-1:0]] = bus.push_addr;
          top_d                    = bus.push_addr;
        end
      end
      default: begin
      end
    endcase
  end

  // Storage needs no reset: only entries below count are ever read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  sticky_flag u_overflow (
    .clk  (clk),
    .rst  (rst),
    .set  (ovf_set),
    .clr  (bus.clear_err),
    .flag (bus.overflow)
  );

  sticky_flag u_underflow (
    .clk  (clk),
    .rst  (rst),
    .set  (unf_set),
    .clr  (bus.clear_err),
    .flag (bus.underflow)
  );

  assign bus.top_addr = top_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty;
  assign bus.full     = full;

endmodule

`default_nettype wire
